// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the multi-cycle controller and the
// instruction/data memories.
interface multicycle_ctrl_if;
  // A request is held high until the memory answers with ready in the same
  // cycle. ready is only sampled while the matching request is high, and a
  // request with ready high completes in that cycle.
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and write-back, with memory timeouts and retire counting.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_ctrl_if.master        mem,
    input  logic [31:0]              Instruction,
    input  logic                     BrTaken,
    output logic                     IRWrite,
    output logic                     ALUSrcB,
    output logic [1:0]               ALUOp,
    output logic                     RegWrite,
    output logic [1:0]               WBSel,
    output logic                     PCWrite,
    output logic                     PCSel,
    output logic [2:0]               state,
    output logic                     halted,
    output logic [1:0]               err_code,
    output logic [31:0]              instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t      state_q;
    state_t      nxt;
    logic [1:0]  nxt_err;
    logic [31:0] tcnt;
    logic        limit_hit;
    logic [6:0]  opc;
    logic        legal;
    logic        unused_instr_bits;

    assign opc               = Instruction[6:0];
    assign unused_instr_bits = ^Instruction[31:7];
    assign state             = state_q;

    // limit_hit means this is the last request cycle allowed without ready
    assign limit_hit = (MEM_TIMEOUT != 0) && (tcnt == 32'(MEM_TIMEOUT - 1));

    always_comb begin
        legal = 1'b0;
        case (opc)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        nxt          = state_q;
        nxt_err      = err_code;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        IRWrite      = 1'b0;
        ALUSrcB      = 1'b0;
        ALUOp        = 2'b00;
        RegWrite     = 1'b0;
        WBSel        = 2'b00;
        PCWrite      = 1'b0;
        PCSel        = 1'b0;
        case (state_q)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ready) begin
                    IRWrite = 1'b1;
                    nxt     = S_DECODE;
                end else if (limit_hit) begin
                    nxt     = S_HALT;
                    nxt_err = 2'b10;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    nxt = S_EXEC;
                end else begin
                    nxt     = S_HALT;
                    nxt_err = 2'b01;
                end
            end
            S_EXEC: begin
                case (opc)
                    OP_R:   begin ALUOp = 2'b10; nxt = S_WB; end
                    OP_IMM: begin ALUOp = 2'b10; ALUSrcB = 1'b1; nxt = S_WB; end
                    OP_LOAD, OP_STORE: begin ALUSrcB = 1'b1; nxt = S_MEM; end
                    OP_BRANCH: begin
                        ALUOp   = 2'b01;
                        PCWrite = 1'b1;
                        PCSel   = BrTaken;
                        nxt     = S_FETCH;
                    end
                    default: nxt = S_WB;
                endcase
            end
            S_MEM: begin
                // address operands stay selected so the address is stable
                mem.dmem_req = 1'b1;
                mem.dmem_we  = (opc == OP_STORE);
                ALUSrcB      = 1'b1;
                if (mem.dmem_ready) begin
                    if (opc == OP_STORE) begin
                        PCWrite = 1'b1;
                        nxt     = S_FETCH;
                    end else begin
                        nxt     = S_WB;
                    end
                end else if (limit_hit) begin
                    nxt     = S_HALT;
                    nxt_err = 2'b11;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                nxt      = S_FETCH;
                case (opc)
                    OP_R:    ALUOp = 2'b10;
                    OP_IMM:  begin ALUOp = 2'b10; ALUSrcB = 1'b1; end
                    OP_LOAD: WBSel = 2'b01;
                    OP_JAL:  begin WBSel = 2'b10; PCSel = 1'b1; end
                    OP_LUI:  WBSel = 2'b11;
                    default: WBSel = 2'b00;
                endcase
            end
            S_HALT: nxt = S_HALT;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            err_code <= 2'b00;
            halted   <= 1'b0;
            instret  <= 32'd0;
            tcnt     <= 32'd0;
        end else begin
            state_q  <= nxt;
            err_code <= nxt_err;
            halted   <= (nxt == S_HALT);
            if (PCWrite) instret <= instret + 32'd1;
            // staying in FETCH/MEM only happens while waiting for ready
            if ((nxt == state_q) && (state_q == S_FETCH || state_q == S_MEM))
                tcnt <= tcnt + 32'd1;
            else
                tcnt <= 32'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction cycle traces are generated from
// the instruction rules and compared against the DUT every cycle.
module tb_multicycle_ctrl;
  localparam int T = 15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [2:0]  state;
    logic        imem_req;
    logic        irwrite;
    logic        dmem_req;
    logic        dmem_we;
    logic        alusrcb;
    logic [1:0]  aluop;
    logic        regwrite;
    logic [1:0]  wbsel;
    logic        pcwrite;
    logic        pcsel;
    logic        halted;
    logic [1:0]  err;
    logic [31:0] instret;
  } outs_t;

  typedef struct packed {
    logic [31:0] ins;
    logic        ir;
    logic        dr;
    logic        br;
  } stim_t;

  localparam int W = $bits(outs_t);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = 32'd0;
  logic        br_taken = 1'b0;
  logic        ir_write, alu_src_b, reg_write, pc_write, pc_sel, halted;
  logic [1:0]  alu_op, wb_sel, err_code;
  logic [2:0]  state;
  logic [31:0] instret;

  multicycle_ctrl_if mif ();

  multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem         (mif),
    .Instruction (instruction),
    .BrTaken     (br_taken),
    .IRWrite     (ir_write),
    .ALUSrcB     (alu_src_b),
    .ALUOp       (alu_op),
    .RegWrite    (reg_write),
    .WBSel       (wb_sel),
    .PCWrite     (pc_write),
    .PCSel       (pc_sel),
    .state       (state),
    .halted      (halted),
    .err_code    (err_code),
    .instret     (instret)
  );

  // clock/reset
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] m_instret;
  logic [1:0]  m_err;
  logic [W-1:0] exp_q[$];
  stim_t       stim_q[$];
  outs_t       obs_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL};
  endfunction

  function automatic outs_t base(input logic [2:0] st);
    outs_t o;
    o = '0;
    o.state = st;
    o.instret = m_instret;
    o.err = m_err;
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t s;
    s.state = state;       s.imem_req = mif.imem_req; s.irwrite = ir_write;
    s.dmem_req = mif.dmem_req; s.dmem_we = mif.dmem_we; s.alusrcb = alu_src_b;
    s.aluop = alu_op;      s.regwrite = reg_write;    s.wbsel = wb_sel;
    s.pcwrite = pc_write;  s.pcsel = pc_sel;          s.halted = halted;
    s.err = err_code;      s.instret = instret;
    return s;
  endfunction

  // driver tasks
  task automatic push(input logic [31:0] ins, input logic ir, input logic dr,
                      input logic br, input outs_t o);
    stim_t s;
    s.ins = ins; s.ir = ir; s.dr = dr; s.br = br;
    stim_q.push_back(s);
    exp_q.push_back(o);
  endtask

  task automatic push_idle();
    push($urandom(), rnd1(), rnd1(), rnd1(), base(3'd0));
  endtask

  task automatic enter_halt(input logic [1:0] e);
    outs_t o;
    m_err = e;
    for (int i = 0; i < 4; i++) begin
      o = base(3'd6);
      o.halted = 1'b1;
      push($urandom(), rnd1(), rnd1(), rnd1(), o);
    end
  endtask

  // Reference: expected cycle trace of one instruction with fw fetch-wait and
  // mw data-wait cycles.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic br);
    outs_t o;
    logic [6:0] op;
    logic rdy;
    op = ins[6:0];
    for (int k = 0; k <= fw; k++) begin
      rdy = (k == fw);
      o = base(3'd1);
      o.imem_req = 1'b1;
      o.irwrite = rdy;
      push($urandom(), rdy, rnd1(), rnd1(), o);
      if (!rdy && k + 1 == T) begin enter_halt(2'b10); return; end
    end
    push(ins, rnd1(), rnd1(), rnd1(), base(3'd2));
    if (!is_legal(op)) begin enter_halt(2'b01); return; end
    o = base(3'd3);
    case (op)
      OP_R:   o.aluop = 2'b10;
      OP_IMM: begin o.aluop = 2'b10; o.alusrcb = 1'b1; end
      OP_LOAD, OP_STORE: o.alusrcb = 1'b1;
      OP_BRANCH: begin o.aluop = 2'b01; o.pcwrite = 1'b1; o.pcsel = br; end
      default: ;
    endcase
    push(ins, rnd1(), rnd1(), (op == OP_BRANCH) ? br : rnd1(), o);
    if (op == OP_BRANCH) begin m_instret++; return; end
    if (op == OP_LOAD || op == OP_STORE) begin
      for (int k = 0; k <= mw; k++) begin
        rdy = (k == mw);
        o = base(3'd4);
        o.dmem_req = 1'b1;
        o.dmem_we = (op == OP_STORE);
        o.alusrcb = 1'b1;
        o.pcwrite = rdy && (op == OP_STORE);
        push(ins, rnd1(), rdy, rnd1(), o);
        if (!rdy && k + 1 == T) begin enter_halt(2'b11); return; end
      end
      if (op == OP_STORE) begin m_instret++; return; end
    end
    o = base(3'd5);
    o.regwrite = 1'b1;
    o.pcwrite = 1'b1;
    case (op)
      OP_R:    o.aluop = 2'b10;
      OP_IMM:  begin o.aluop = 2'b10; o.alusrcb = 1'b1; end
      OP_LOAD: o.wbsel = 2'b01;
      OP_JAL:  begin o.wbsel = 2'b10; o.pcsel = 1'b1; end
      OP_LUI:  o.wbsel = 2'b11;
      default: ;
    endcase
    push(ins, rnd1(), rnd1(), rnd1(), o);
    m_instret++;
  endtask

  // scoreboard: apply one planned cycle, compare at the falling edge
  task automatic flush(input int n);
    stim_t s;
    outs_t got;
    logic [W-1:0] exp;
    for (int i = 0; i < n && stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      exp = exp_q.pop_front();
      instruction = s.ins;
      mif.imem_ready = s.ir;
      mif.dmem_ready = s.dr;
      br_taken = s.br;
      @(negedge clk);
      got = sample();
      check("cycle", 64'(got), 64'(exp));
      obs_q.push_back(got);
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  // entered and left at posedge+1
  task automatic do_reset();
    stim_q.delete();
    exp_q.delete();
    rst_n = 1'b0;
    mif.imem_ready = 1'b1;
    mif.dmem_ready = 1'b1;
    br_taken = 1'b1;
    instruction = 32'h0000_0063;
    m_instret = 32'd0;
    m_err = 2'b00;
    @(negedge clk);
    check("reset", 64'(sample()), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int count_state(input logic [2:0] st);
    int c = 0;
    foreach (obs_q[i]) if (obs_q[i].state == st) c++;
    return c;
  endfunction

  initial begin
    logic [31:0] r;
    logic [6:0] ops[7];
    int fw, mw;
    ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL};
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // ADDI x1,x0,5
    obs_q.delete();
    push_idle();
    run_instr(32'h0050_0093, 0, 0, 1'b0);
    flush(100);
    check("addi_states", {obs_q[1].state, obs_q[2].state, obs_q[3].state, obs_q[4].state},
          {3'd1, 3'd2, 3'd3, 3'd5});
    check("addi_exec_srcb", obs_q[3].alusrcb, 1);
    check("addi_wb", {obs_q[4].regwrite, obs_q[4].wbsel}, 3'b100);
    check("addi_instret", instret, 1);

    // LW with 3 wait cycles on dmem
    obs_q.delete();
    run_instr(32'h0000_A103, 0, 3, 1'b0);
    flush(100);
    check("lw_cycles", obs_q.size(), 8);
    check("lw_mem_cycles", count_state(3'd4), 4);
    check("lw_wbsel", {obs_q[7].state, obs_q[7].wbsel}, {3'd5, 2'b01});

    // BEQ taken / not taken
    obs_q.delete();
    run_instr(32'h0000_0063, 0, 0, 1'b1);
    flush(100);
    check("beq_t_cycles", obs_q.size(), 3);
    check("beq_t_exec", {obs_q[2].pcwrite, obs_q[2].pcsel, obs_q[2].regwrite}, 3'b110);
    obs_q.delete();
    run_instr(32'h0000_0063, 0, 0, 1'b0);
    flush(100);
    check("beq_nt_exec", {obs_q[2].pcwrite, obs_q[2].pcsel, obs_q[2].regwrite}, 3'b100);

    // imem ready on the 15th request cycle: no timeout
    obs_q.delete();
    run_instr(32'h0050_0093, 14, 0, 1'b0);
    flush(100);
    check("fetch_limit_ok", {obs_q[14].irwrite, obs_q[15].state}, {1'b1, 3'd2});

    // dmem ready on the 15th request cycle: no timeout
    obs_q.delete();
    run_instr(32'h0020_A023, 0, 14, 1'b0);
    flush(100);
    check("mem_limit_ok", {obs_q[17].pcwrite, obs_q[17].err}, {1'b1, 2'b00});

    // randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      r = $urandom();
      r[6:0] = ops[$urandom_range(0, 6)];
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 14) : $urandom_range(0, 2);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 14) : $urandom_range(0, 2);
      run_instr(r, fw, mw, rnd1());
      flush(100);
    end

    // instret wrap on a JAL
    do_reset();
    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    m_instret = 32'hFFFF_FFFF;
    obs_q.delete();
    push_idle();
    run_instr(32'h0000_006F, 0, 0, 1'b0);
    flush(100);
    check("jal_wb", {obs_q[4].wbsel, obs_q[4].pcsel}, 3'b101);
    check("instret_wrap", instret, 0);

    // illegal opcode
    obs_q.delete();
    run_instr(32'hFFFF_FFFF, 0, 0, 1'b0);
    flush(100);
    check("illegal_halt", {obs_q[5].state, obs_q[5].halted, obs_q[5].err}, {3'd6, 1'b1, 2'b01});
    do_reset();

    // imem timeout
    obs_q.delete();
    push_idle();
    run_instr(32'h0050_0093, 40, 0, 1'b0);
    flush(100);
    check("imem_to_fetches", count_state(3'd1), 15);
    check("imem_to_halt", {obs_q[16].state, obs_q[16].err}, {3'd6, 2'b10});
    do_reset();

    // dmem timeout on a store
    obs_q.delete();
    push_idle();
    run_instr(32'h0020_A023, 0, 40, 1'b0);
    flush(100);
    check("dmem_to_halt", {obs_q[obs_q.size() - 1].state, obs_q[obs_q.size() - 1].err},
          {3'd6, 2'b11});
    do_reset();

    // reset during a LOAD's memory wait, then resume normally
    push_idle();
    run_instr(32'h0000_A103, 0, 8, 1'b0);
    flush(6);
    do_reset();
    push_idle();
    run_instr(32'h0050_0093, 1, 0, 1'b0);
    flush(100);
    check("post_abort_instret", instret, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end
endmodule
